// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single synchronous single-port memory.
// An instruction-fetch port (read only) and a data port (load/store) compete
// for the memory. Each access takes exactly three cycles:
//   IDLE  : requests sampled on the closing edge; winner's addr/we/wdata latched
//   GRANT : mem_en (and mem_we for stores) driven, winner's gnt pulses
//   CAPT  : memory read data is valid; captured on the closing edge
// The winner's valid then pulses during the following IDLE cycle, so a
// requester that keeps its request high through that cycle is served again
// back-to-back (one access per three cycles).
//
// Arbitration on simultaneous requests:
//   ARB_ROUND_ROBIN_EN undefined : data port always wins (fixed priority).
//   ARB_ROUND_ROBIN_EN defined   : the port not granted most recently wins;
//                                  after reset the fetch port counts as the
//                                  most recently granted, so data wins first.
//
// Ports
//   clk_main            sole clock, rising edge
//   reset               synchronous active-high reset (aborts any access)
//   if_req / if_addr    fetch request (held until if_gnt) and address
//   if_gnt / if_valid   fetch grant pulse / fetch data-valid pulse
//   if_rdata            fetched word (updated only on fetch completion)
//   d_req / d_we        data request (held until d_gnt); 1 = store, 0 = load
//   d_addr / d_wdata    data address and store data
//   d_gnt / d_valid     data grant pulse / data completion pulse
//   d_rdata             load data (unchanged by stores)
//   mem_en / mem_we     memory enable and write strobe (GRANT cycle only)
//   mem_addr/mem_wdata  memory address and write data
//   mem_rdata           memory read data, valid one cycle after mem_en
//   busy                high whenever the FSM is not in IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk_main,
  input  logic        reset,
  input  logic        if_req,
  input  logic [5:0]  if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [5:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CAPT  = 2'd2
  } state_t;

  state_t      state_q;

  // Output registers
  logic        if_gnt_q;
  logic        if_valid_q;
  logic [15:0] if_rdata_q;
  logic        d_gnt_q;
  logic        d_valid_q;
  logic [15:0] d_rdata_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [5:0]  mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        busy_q;

  // Owner of the access in flight, remembered for the capture edge
  logic        owner_data_q;
  logic        owner_we_q;

  // Combinational arbitration result: 1 = data port wins this IDLE sample
  logic        win_data;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = fetch port was granted most recently
  logic        last_fetch_q;

  always_comb begin
    win_data = d_req;
    if (d_req && if_req) begin
      win_data = last_fetch_q;
    end
  end
`else
  // Fixed priority: any data request beats a fetch request
  assign win_data = d_req;
`endif

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q      <= IDLE;
      if_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      owner_data_q <= 1'b0;
      owner_we_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_fetch_q <= 1'b1;
`endif
    end else begin
      // Pulse outputs default low; each state raises only what it owns
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            state_q      <= GRANT;
            busy_q       <= 1'b1;
            mem_en_q     <= 1'b1;
            owner_data_q <= win_data;
            // Address/data are copied here so requester changes after this
            // edge cannot disturb the access.
            if (win_data) begin
              d_gnt_q     <= 1'b1;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              owner_we_q  <= d_we;
            end else begin
              if_gnt_q    <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              owner_we_q  <= 1'b0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_fetch_q <= ~win_data;
`endif
          end
        end

        GRANT: begin
          // Memory samples the command on this edge; data arrives in CAPT
          state_q <= CAPT;
        end

        CAPT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (owner_data_q) begin
            d_valid_q <= 1'b1;
            // Stores complete without touching the load-data register
            if (!owner_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end else begin
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios (reset values, single fetch, single store, simultaneous
// requests, reset abort) followed by a randomized phase. In the random phase
// two independent driver processes issue fetches (addresses 0..31, never
// written) and loads/stores (addresses 32..63). Each driver computes the
// expected response from a reference memory array when it issues a request
// and pushes it into a per-port queue; a monitor process pops and checks on
// every grant and every valid pulse.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk_main;
  logic        reset;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  mem_arbiter dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clk_main = 1'b0;
    forever #5 clk_main = ~clk_main;
  end

  // Synchronous memory attached to the arbiter
  logic [15:0] ram [64];
  always @(posedge clk_main) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [64];
  logic [15:0] last_load;

  function automatic logic [15:0] init_val(input int a);
    if (a == 5) return 16'hA1B2;
    return (16'(a) * 16'h0421) ^ 16'h3C5A;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, required one", name);
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          due;
  } txn_t;

  txn_t if_gq[$];
  txn_t if_vq[$];
  txn_t d_gq[$];
  txn_t d_vq[$];

  // ---------------------------------------------------------------- monitor
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   last_gnt = -1;
  txn_t mt;

  always @(negedge clk_main) begin
    cyc++;
    if (mon_en && !reset) begin
      if (if_gnt || d_gnt) begin
        chk("gnt_exclusive", 32'(if_gnt & d_gnt), 0);
        chk("gnt_busy", 32'(busy), 1);
        chk("gnt_mem_en", 32'(mem_en), 1);
        if (last_gnt >= 0) chk("gnt_spacing_ge3", 32'((cyc - last_gnt) >= 3), 1);
        last_gnt = cyc;
      end else begin
        chk("no_gnt_mem_strobes", 32'({mem_en, mem_we}), 0);
      end

      if (if_gnt) begin
        if (if_gq.size() == 0) fail("if_gnt_expected");
        else begin
          mt = if_gq.pop_front();
          chk("if_mem_addr", 32'(mem_addr), 32'(mt.addr));
          chk("if_mem_we", 32'(mem_we), 0);
          mt.due = cyc + 2;
          if_vq.push_back(mt);
        end
      end
      if (d_gnt) begin
        if (d_gq.size() == 0) fail("d_gnt_expected");
        else begin
          mt = d_gq.pop_front();
          chk("d_mem_addr", 32'(mem_addr), 32'(mt.addr));
          chk("d_mem_we", 32'(mem_we), 32'(mt.we));
          if (mt.we) chk("d_mem_wdata", 32'(mem_wdata), 32'(mt.wdata));
          mt.due = cyc + 2;
          d_vq.push_back(mt);
        end
      end

      if (if_valid) begin
        chk("if_valid_busy", 32'(busy), 0);
        if (if_vq.size() == 0) fail("if_valid_expected");
        else begin
          mt = if_vq.pop_front();
          chk("if_valid_latency", 32'(cyc), 32'(mt.due));
          chk("if_rdata", 32'(if_rdata), 32'(mt.rdata));
          $display("txn I addr=%02h rdata=%04h exp=%04h", mt.addr, if_rdata, mt.rdata);
        end
      end else if (if_vq.size() > 0 && cyc > if_vq[0].due) begin
        fail("if_valid_missing");
        void'(if_vq.pop_front());
      end

      if (d_valid) begin
        chk("d_valid_busy", 32'(busy), 0);
        if (d_vq.size() == 0) fail("d_valid_expected");
        else begin
          mt = d_vq.pop_front();
          chk("d_valid_latency", 32'(cyc), 32'(mt.due));
          chk("d_rdata", 32'(d_rdata), 32'(mt.rdata));
          $display("txn D we=%0d addr=%02h wdata=%04h rdata=%04h exp=%04h",
                   mt.we, mt.addr, mt.wdata, d_rdata, mt.rdata);
        end
      end else if (d_vq.size() > 0 && cyc > d_vq[0].due) begin
        fail("d_valid_missing");
        void'(d_vq.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic fetch_driver(input int n);
    txn_t t;
    bit   got;
    int   gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        if_req = 1'b0;
        repeat (gap) @(negedge clk_main);
      end
      t.we    = 1'b0;
      t.addr  = 6'($urandom_range(0, 31));
      t.wdata = '0;
      t.rdata = ref_mem[t.addr];
      t.due   = 0;
      if_addr = t.addr;
      if_req  = 1'b1;
      if_gq.push_back(t);
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk_main);
        got = if_gnt;
      end
      if (!got) begin
        fail("if_gnt_timeout");
        if_req = 1'b0;
      end
      // Scramble the address after the grant; the access must be unaffected
      if_addr = 6'($urandom);
    end
    if_req = 1'b0;
  endtask

  task automatic data_driver(input int n);
    txn_t t;
    bit   got;
    int   gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        d_req = 1'b0;
        repeat (gap) @(negedge clk_main);
      end
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = 6'($urandom_range(32, 63));
      t.wdata = 16'($urandom);
      t.due   = 0;
      if (t.we) begin
        t.rdata         = last_load;
        ref_mem[t.addr] = t.wdata;
      end else begin
        t.rdata   = ref_mem[t.addr];
        last_load = t.rdata;
      end
      d_we    = t.we;
      d_addr  = t.addr;
      d_wdata = t.wdata;
      d_req   = 1'b1;
      d_gq.push_back(t);
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk_main);
        got = d_gnt;
      end
      if (!got) begin
        fail("d_gnt_timeout");
        d_req = 1'b0;
      end
      d_addr  = 6'($urandom);
      d_wdata = 16'($urandom);
    end
    d_req = 1'b0;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  logic [2:0] seq;
  bit         exp_d;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    last_load = '0;
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk_main);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en_we", 32'({mem_en, mem_we}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_gnts", 32'({if_gnt, d_gnt}), 0);
    chk("rst_valids", 32'({if_valid, d_valid}), 0);
    chk("rst_if_rdata", 32'(if_rdata), 0);
    chk("rst_d_rdata", 32'(d_rdata), 0);
    reset = 1'b0;

    // No request: stays idle
    repeat (2) @(negedge clk_main);
    chk("idle_no_req_busy", 32'(busy), 0);
    chk("idle_no_req_mem_en", 32'(mem_en), 0);

    // Single fetch from 0x05
    if_addr = 6'h05;
    if_req  = 1'b1;
    @(negedge clk_main);
    chk("f1_if_gnt", 32'(if_gnt), 1);
    chk("f1_d_gnt", 32'(d_gnt), 0);
    chk("f1_mem_en", 32'(mem_en), 1);
    chk("f1_mem_we", 32'(mem_we), 0);
    chk("f1_mem_addr", 32'(mem_addr), 32'h05);
    chk("f1_busy", 32'(busy), 1);
    if_req  = 1'b0;
    if_addr = 6'h2A;
    @(negedge clk_main);
    chk("f1_capt_gnt", 32'(if_gnt), 0);
    chk("f1_capt_mem_en", 32'(mem_en), 0);
    chk("f1_capt_valid", 32'(if_valid), 0);
    @(negedge clk_main);
    chk("f1_if_valid", 32'(if_valid), 1);
    chk("f1_if_rdata", 32'(if_rdata), 32'hA1B2);
    chk("f1_valid_busy", 32'(busy), 0);
    @(negedge clk_main);
    chk("f1_valid_pulse", 32'(if_valid), 0);
    chk("f1_if_rdata_hold", 32'(if_rdata), 32'hA1B2);

    // Single store 0x1234 -> 0x3F
    d_we    = 1'b1;
    d_addr  = 6'h3F;
    d_wdata = 16'h1234;
    d_req   = 1'b1;
    @(negedge clk_main);
    chk("s1_d_gnt", 32'(d_gnt), 1);
    chk("s1_if_gnt", 32'(if_gnt), 0);
    chk("s1_mem_we", 32'(mem_we), 1);
    chk("s1_mem_addr", 32'(mem_addr), 32'h3F);
    chk("s1_mem_wdata", 32'(mem_wdata), 32'h1234);
    d_req   = 1'b0;
    d_addr  = 6'h00;
    d_wdata = 16'hFFFF;
    @(negedge clk_main);
    chk("s1_mem_we_one_cycle", 32'(mem_we), 0);
    chk("s1_capt_valid", 32'(d_valid), 0);
    @(negedge clk_main);
    chk("s1_d_valid", 32'(d_valid), 1);
    chk("s1_d_rdata_unchanged", 32'(d_rdata), 0);
    chk("s1_valid_busy", 32'(busy), 0);
    ref_mem[63] = 16'h1234;

    // Load back from 0x3F
    d_we  = 1'b0;
    d_addr = 6'h3F;
    d_req = 1'b1;
    @(negedge clk_main);
    chk("l1_d_gnt", 32'(d_gnt), 1);
    chk("l1_mem_we", 32'(mem_we), 0);
    d_req = 1'b0;
    repeat (2) @(negedge clk_main);
    chk("l1_d_valid", 32'(d_valid), 1);
    chk("l1_d_rdata", 32'(d_rdata), 32'h1234);

    // Simultaneous held requests after reset: D,I,D (RR) or D,D,D (fixed)
    reset = 1'b1;
    @(negedge clk_main);
    reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    seq = 3'b101;
`else
    seq = 3'b111;
`endif
    if_addr = 6'h07;
    d_we    = 1'b0;
    d_addr  = 6'h21;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_main);
      exp_d = seq[(c - 1) / 3];
      if (c % 3 == 1) begin
        chk($sformatf("sim_d_gnt_c%0d", c), 32'(d_gnt), 32'(exp_d));
        chk($sformatf("sim_if_gnt_c%0d", c), 32'(if_gnt), 32'(!exp_d));
        chk($sformatf("sim_busy_c%0d", c), 32'(busy), 1);
      end else begin
        chk($sformatf("sim_no_gnt_c%0d", c), 32'({if_gnt, d_gnt}), 0);
      end
      if (c % 3 == 0) begin
        chk($sformatf("sim_d_valid_c%0d", c), 32'(d_valid), 32'(exp_d));
        chk($sformatf("sim_if_valid_c%0d", c), 32'(if_valid), 32'(!exp_d));
        chk($sformatf("sim_valid_busy_c%0d", c), 32'(busy), 0);
      end
      if (c == 7) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    @(negedge clk_main);
    chk("sim_drained_busy", 32'(busy), 0);
    chk("sim_drained_gnts", 32'({if_gnt, d_gnt}), 0);

    // Reset during the GRANT cycle of a store (same value as stored already,
    // so the model memory stays exact whether or not the write landed)
    d_we    = 1'b1;
    d_addr  = 6'h20;
    d_wdata = ref_mem[32];
    d_req   = 1'b1;
    @(negedge clk_main);
    chk("ab_d_gnt", 32'(d_gnt), 1);
    chk("ab_mem_we", 32'(mem_we), 1);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk_main);
    chk("ab_mem_we_cleared", 32'(mem_we), 0);
    chk("ab_mem_en_cleared", 32'(mem_en), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_d_gnt_low", 32'(d_gnt), 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_main);
      chk($sformatf("ab_no_valid_%0d", c), 32'({if_valid, d_valid}), 0);
      chk($sformatf("ab_idle_%0d", c), 32'(busy), 0);
    end
    last_load = '0;

    // Randomized traffic on both ports
    last_gnt = -1;
    mon_en   = 1'b1;
    fork
      fetch_driver(30);
      data_driver(30);
    join
    for (int k = 0; k < 30; k++) begin
      if (if_gq.size() == 0 && if_vq.size() == 0 &&
          d_gq.size() == 0 && d_vq.size() == 0) break;
      @(negedge clk_main);
    end
    @(negedge clk_main);
    mon_en = 1'b0;
    chk("drain_if_queues", 32'(if_gq.size() + if_vq.size()), 0);
    chk("drain_d_queues", 32'(d_gq.size() + d_vq.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
